// File: rtl/fifo_sync_pkg.sv
// Shared defaults and elaboration helpers for the RAM-backed first-word-fall-through FIFO.
package fifo_sync_pkg;

    localparam int DEF_D_WIDTH   = 64;
    localparam int DEF_D_DEPTH   = 32;
    localparam int DEF_AF_MARGIN = 4;

    // Depth must be a power of two so the pointers wrap without extra compare logic.
    function automatic bit depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Producer/consumer handshake and status bundle for fifo_sync; slave is the FIFO side.
interface fifo_sync_if
    import fifo_sync_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int D_DEPTH = DEF_D_DEPTH
);

    localparam int L_WIDTH = $clog2(D_DEPTH + 1);

    logic               in_valid_i;
    logic [D_WIDTH-1:0] in_data_i;
    logic               in_ready_o;
    logic               out_valid_o;
    logic [D_WIDTH-1:0] out_data_o;
    logic               out_ready_i;
    logic [L_WIDTH-1:0] level_o;
    logic               full_o;
    logic               empty_o;
    logic               afull_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, level_o, full_o, empty_o, afull_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, level_o, full_o, empty_o, afull_o
    );

endinterface

// File: rtl/fifo_sync_ram_dp.sv
// Dual-port RAM with optional registered read on each port, intended for common-clock use.
module ram_dp #(
    parameter int D_WIDTH = 64,
    parameter int D_DEPTH = 32,
    parameter int A_WIDTH = $clog2(D_DEPTH),
    parameter int INIT    = 0,
    parameter int REG_OUT = 1
) (
    input  logic               clk_a,
    input  logic               en_a,
    input  logic               we_a,
    input  logic [A_WIDTH-1:0] addr_a,
    input  logic [D_WIDTH-1:0] din_a,
    output logic [D_WIDTH-1:0] dout_a,
    input  logic               clk_b,
    input  logic               en_b,
    input  logic               we_b,
    input  logic [A_WIDTH-1:0] addr_b,
    input  logic [D_WIDTH-1:0] din_b,
    output logic [D_WIDTH-1:0] dout_b
);

    localparam logic [D_WIDTH-1:0] INIT_WORD = D_WIDTH'(INIT);

    logic [D_WIDTH-1:0] mem [D_DEPTH];

    // Both ports commit writes on clk_a so the array has a single writer; port B wins a same-address collision.
    always_ff @(posedge clk_a) begin
        if (en_a && we_a) begin
            mem[addr_a] <= din_a;
        end
        if (en_b && we_b) begin
            mem[addr_b] <= din_b;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [D_WIDTH-1:0] q_a;
            logic [D_WIDTH-1:0] q_b;

            // Addresses past a non-power-of-two depth read back INIT instead of an undefined slot.
            always_ff @(posedge clk_a) begin
                if (en_a) begin
                    q_a <= (32'(addr_a) < D_DEPTH) ? mem[addr_a] : INIT_WORD;
                end
            end

            always_ff @(posedge clk_b) begin
                if (en_b) begin
                    q_b <= (32'(addr_b) < D_DEPTH) ? mem[addr_b] : INIT_WORD;
                end
            end

            assign dout_a = q_a;
            assign dout_b = q_b;
        end else begin : g_comb_out
            assign dout_a = (32'(addr_a) < D_DEPTH) ? mem[addr_a] : INIT_WORD;
            assign dout_b = (32'(addr_b) < D_DEPTH) ? mem[addr_b] : INIT_WORD;
        end
    endgenerate

endmodule

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO: RAM port A writes, port B's read register is the output stage.
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int D_WIDTH  = DEF_D_WIDTH,
    parameter int D_DEPTH  = DEF_D_DEPTH,
    parameter int AF_LEVEL = D_DEPTH - DEF_AF_MARGIN
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    fifo_sync_if.slave bus
);

    localparam int A_WIDTH = $clog2(D_DEPTH);
    localparam int L_WIDTH = $clog2(D_DEPTH + 1);

    generate
        if (!depth_ok(D_DEPTH)) begin : g_bad_depth
            $error("fifo_sync: D_DEPTH must be a power of two and at least 4");
        end
    endgenerate

    logic [A_WIDTH-1:0] wr_ptr;
    logic [A_WIDTH-1:0] rd_ptr;
    logic [L_WIDTH-1:0] level;
    logic               out_valid;
    logic [L_WIDTH-1:0] ram_cnt;
    logic               full;
    logic               in_ready;
    logic               wr_hs;
    logic               rd_hs;
    logic               rd_en;
    logic [D_WIDTH-1:0] unused_dout_a;

    assign full     = (level == L_WIDTH'(D_DEPTH));
    assign in_ready = !full;
    assign wr_hs    = bus.in_valid_i && in_ready;
    assign rd_hs    = out_valid && bus.out_ready_i;

    // Only words still in the RAM may be fetched, so a slot being written this edge is never read.
    assign ram_cnt = level - L_WIDTH'(out_valid);
    assign rd_en   = (ram_cnt != '0) && (!out_valid || bus.out_ready_i);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (wr_hs) begin
                wr_ptr <= wr_ptr + A_WIDTH'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + A_WIDTH'(1);
            end
            if (wr_hs && !rd_hs) begin
                level <= level + L_WIDTH'(1);
            end else if (rd_hs && !wr_hs) begin
                level <= level - L_WIDTH'(1);
            end
            if (rd_en) begin
                out_valid <= 1'b1;
            end else if (rd_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

    ram_dp #(
        .D_WIDTH (D_WIDTH),
        .D_DEPTH (D_DEPTH),
        .A_WIDTH (A_WIDTH),
        .INIT    (0),
        .REG_OUT (1)
    ) u_ram (
        .clk_a  (clk_i),
        .en_a   (wr_hs),
        .we_a   (wr_hs),
        .addr_a (wr_ptr),
        .din_a  (bus.in_data_i),
        .dout_a (unused_dout_a),
        .clk_b  (clk_i),
        .en_b   (rd_en),
        .we_b   (1'b0),
        .addr_b (rd_ptr),
        .din_b  ({D_WIDTH{1'b0}}),
        .dout_b (bus.out_data_o)
    );

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.level_o     = level;
    assign bus.full_o      = full;
    assign bus.empty_o     = (level == '0);
    assign bus.afull_o     = (level >= L_WIDTH'(AF_LEVEL));

endmodule
